execute_stage_mc: RTL and testbench

Parametrised Y86 execute stage with a registered E→M boundary, architectural condition-code register, exception-gated CC update, and a multi-cycle `mulq` extension. It sits between the decode/E register and the memory stage. Single-cycle ops retire in one clock. `mulq` runs an iterative shift-add multiplier and stalls upstream through `e_busy`.

---
 rtl/y86_pkg.sv | 54 +++++
 rtl/seq_multiplier.sv | 63 ++++++
 rtl/execute_stage_mc.sv | 165 ++++++++++++++++
 tb/tb_execute_stage_mc.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86 encodings, condition-code type and branch/cmov condition evaluation.
package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [2:0] S_AOK = 3'd1;
   localparam logic [2:0] S_ADR = 3'd2;
   localparam logic [2:0] S_INS = 3'd3;
   localparam logic [2:0] S_HLT = 3'd4;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_XOR = 4'd3;
   localparam logic [3:0] ALU_MUL = 4'd4;

   localparam logic [3:0] R_ESP  = 4'h4;
   localparam logic [3:0] R_NONE = 4'hF;

   typedef struct packed {
      logic zf;
      logic sf;
      logic of;
   } cc_t;

   localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

   function automatic logic cond_eval(input logic [3:0] ifun, input cc_t cc);
      logic lt;
      lt = cc.sf ^ cc.of;
      case (ifun)
         4'd0:    return 1'b1;
         4'd1:    return lt | cc.zf;
         4'd2:    return lt;
         4'd3:    return cc.zf;
         4'd4:    return ~cc.zf;
         4'd5:    return ~lt;
         4'd6:    return ~lt & ~cc.zf;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Shift-add multiplier: WIDTH edges from start to result, bit 0 handled on the load edge.
// busy is combinational on start so the caller can stall in the same cycle; done/product valid on the last edge.
module seq_multiplier #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic {ST_IDLE, ST_MUL} mul_state_t;

   mul_state_t       state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_next;

   assign acc_next = acc + (mplier[0] ? mcand : '0);
   assign product  = acc_next;
   assign done     = (state == ST_MUL) && (count == CW'(WIDTH - 2));
   assign busy     = start || (state == ST_MUL);

   // count tracks the last multiplier bit folded in; the final bit lands on the done edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         count  <= '0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state  <= ST_MUL;
                  count  <= '0;
                  mcand  <= a << 1;
                  mplier <= b >> 1;
                  acc    <= b[0] ? a : '0;
               end
            end
            ST_MUL: begin
               acc    <= acc_next;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               count  <= count + 1'b1;
               if (done) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/execute_stage_mc.sv
// Y86 execute stage with registered E->M outputs and CC; single-cycle ops land one edge after sampling.
// mulq holds e_busy for WIDTH cycles (bubbles out meanwhile) and bubbles once more while upstream releases it.
module execute_stage_mc
   import y86_pkg::*;
#(
   parameter int WIDTH  = 64,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       E_stat,
   input  logic [3:0]       E_icode,
   input  logic [3:0]       E_ifun,
   input  logic [WIDTH-1:0] E_valC,
   input  logic [WIDTH-1:0] E_valA,
   input  logic [WIDTH-1:0] E_valB,
   input  logic [3:0]       E_dstE,
   input  logic [3:0]       E_dstM,
   input  logic [2:0]       m_stat,
   input  logic [2:0]       W_stat,
   output logic             e_busy,
   output logic [2:0]       e_stat,
   output logic [3:0]       e_icode,
   output logic             e_Cnd,
   output logic [WIDTH-1:0] e_valE,
   output logic [WIDTH-1:0] e_valA,
   output logic [3:0]       e_dstE,
   output logic [3:0]       e_dstM
);

   localparam logic [WIDTH-1:0] STK_DN = {{(WIDTH-4){1'b1}}, 4'b1000};
   localparam logic [WIDTH-1:0] STK_UP = WIDTH'(8);

   cc_t              cc;
   cc_t              cc_res;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [WIDTH-1:0] alu_r;
   logic [WIDTH-1:0] mul_product;
   logic             of_r;
   logic             is_opq;
   logic             ifun_ok;
   logic             sins;
   logic             is_mul;
   logic             mul_start;
   logic             mul_busy;
   logic             mul_done;
   logic             done_q;
   logic             cnd;
   logic             cc_gate;

   assign is_opq  = (E_icode == I_OPQ);
   assign ifun_ok = (E_ifun <= ALU_XOR) || (MUL_EN && (E_ifun == ALU_MUL));
   assign sins    = is_opq && !ifun_ok;
   assign is_mul  = MUL_EN && is_opq && (E_ifun == ALU_MUL);
   // done_q marks the cycle where E still holds the mulq that just retired
   assign mul_start = is_mul && !done_q && !rst;
   assign e_busy    = mul_busy;
   assign cnd = ((E_icode == I_RRMOVQ) || (E_icode == I_JXX)) ? cond_eval(E_ifun, cc) : 1'b0;
   assign cc_gate = is_opq && ifun_ok && (m_stat == S_AOK) && (W_stat == S_AOK)
                    && (is_mul ? mul_done : 1'b1);

   seq_multiplier #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (E_valA),
      .b       (E_valB),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   always_comb begin
      alu_a = '0;
      alu_b = '0;
      case (E_icode)
         I_RRMOVQ, I_OPQ:              alu_a = E_valA;
         I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = E_valC;
         I_CALL, I_PUSHQ:              alu_a = STK_DN;
         I_RET, I_POPQ:                alu_a = STK_UP;
         default:                      alu_a = '0;
      endcase
      case (E_icode)
         I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = E_valB;
         default:                                                alu_b = '0;
      endcase
   end

   always_comb begin
      alu_r = alu_a + alu_b;
      of_r  = 1'b0;
      if (is_opq) begin
         case (E_ifun)
            ALU_ADD: begin
               alu_r = alu_b + alu_a;
               of_r  = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (alu_r[WIDTH-1] != alu_a[WIDTH-1]);
            end
            ALU_SUB: begin
               alu_r = alu_b - alu_a;
               of_r  = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (alu_r[WIDTH-1] != alu_b[WIDTH-1]);
            end
            ALU_AND: alu_r = alu_b & alu_a;
            ALU_XOR: alu_r = alu_b ^ alu_a;
            default: alu_r = '0;
         endcase
      end
   end

   always_comb begin
      cc_res = cc;
      if (mul_done) begin
         cc_res.zf = (mul_product == '0);
         cc_res.sf = mul_product[WIDTH-1];
         cc_res.of = 1'b0;
      end else begin
         cc_res.zf = (alu_r == '0);
         cc_res.sf = alu_r[WIDTH-1];
         cc_res.of = of_r;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cc      <= CC_RESET;
         done_q  <= 1'b0;
         e_stat  <= S_AOK;
         e_icode <= I_NOP;
         e_Cnd   <= 1'b0;
         e_valE  <= '0;
         e_valA  <= '0;
         e_dstE  <= R_NONE;
         e_dstM  <= R_NONE;
      end else begin
         done_q <= mul_done;
         if (cc_gate) cc <= cc_res;
         if (mul_done) begin
            e_stat  <= E_stat;
            e_icode <= E_icode;
            e_Cnd   <= 1'b0;
            e_valE  <= mul_product;
            e_valA  <= E_valA;
            e_dstE  <= E_dstE;
            e_dstM  <= E_dstM;
         end else if (mul_busy || done_q) begin
            e_stat  <= S_AOK;
            e_icode <= I_NOP;
            e_Cnd   <= 1'b0;
            e_valE  <= '0;
            e_valA  <= '0;
            e_dstE  <= R_NONE;
            e_dstM  <= R_NONE;
         end else begin
            e_stat  <= sins ? S_INS : E_stat;
            e_icode <= E_icode;
            e_Cnd   <= cnd;
            e_valE  <= alu_r;
            e_valA  <= E_valA;
            e_dstE  <= (sins || ((E_icode == I_RRMOVQ) && !cnd)) ? R_NONE : E_dstE;
            e_dstM  <= E_dstM;
         end
      end
   end

endmodule

// File: tb/tb_execute_stage_mc.sv
// Directed bench for execute_stage_mc: vector table for single-cycle ops, hand sequences for mulq and reset abort.
module tb_execute_stage_mc;
   import y86_pkg::*;

   localparam int W = 64;

   logic         clk = 1'b0;
   logic         rst;
   logic [2:0]   E_stat, m_stat, W_stat;
   logic [3:0]   E_icode, E_ifun, E_dstE, E_dstM;
   logic [W-1:0] E_valC, E_valA, E_valB;

   logic         e_busy, e_Cnd;
   logic [2:0]   e_stat;
   logic [3:0]   e_icode, e_dstE, e_dstM;
   logic [W-1:0] e_valE, e_valA;

   logic         n_busy, n_Cnd;
   logic [2:0]   n_stat;
   logic [3:0]   n_icode, n_dstE, n_dstM;
   logic [W-1:0] n_valE, n_valA;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   execute_stage_mc #(.WIDTH(W), .MUL_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
      .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM),
      .m_stat(m_stat), .W_stat(W_stat), .e_busy(e_busy), .e_stat(e_stat), .e_icode(e_icode),
      .e_Cnd(e_Cnd), .e_valE(e_valE), .e_valA(e_valA), .e_dstE(e_dstE), .e_dstM(e_dstM)
   );

   execute_stage_mc #(.WIDTH(W), .MUL_EN(1'b0)) dut_nomul (
      .clk(clk), .rst(rst), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
      .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM),
      .m_stat(m_stat), .W_stat(W_stat), .e_busy(n_busy), .e_stat(n_stat), .e_icode(n_icode),
      .e_Cnd(n_Cnd), .e_valE(n_valE), .e_valA(n_valA), .e_dstE(n_dstE), .e_dstM(n_dstM)
   );

   typedef struct {
      logic [2:0]   stat;
      logic [3:0]   icode;
      logic [3:0]   ifun;
      logic [W-1:0] valA;
      logic [W-1:0] valB;
      logic [W-1:0] valC;
      logic [3:0]   dstE;
      logic [3:0]   dstM;
      logic [2:0]   mst;
      logic [2:0]   wst;
      logic [2:0]   x_stat;
      logic         x_cnd;
      logic         chk_val;
      logic [W-1:0] x_valE;
      logic [3:0]   x_dstE;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(logic [2:0] stat, logic [3:0] icode, logic [3:0] ifun,
                               logic [W-1:0] va, logic [W-1:0] vb, logic [W-1:0] vc,
                               logic [3:0] de, logic [3:0] dm, logic [2:0] mst, logic [2:0] wst,
                               logic [2:0] xs, logic xc, logic cv, logic [W-1:0] xv, logic [3:0] xd);
      vec_t v;
      v.stat = stat; v.icode = icode; v.ifun = ifun; v.valA = va; v.valB = vb; v.valC = vc;
      v.dstE = de; v.dstM = dm; v.mst = mst; v.wst = wst;
      v.x_stat = xs; v.x_cnd = xc; v.chk_val = cv; v.x_valE = xv; v.x_dstE = xd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic drive(input logic [2:0] stat, input logic [3:0] icode, input logic [3:0] ifun,
                        input logic [W-1:0] va, input logic [W-1:0] vb, input logic [W-1:0] vc,
                        input logic [3:0] de, input logic [3:0] dm);
      E_stat = stat; E_icode = icode; E_ifun = ifun;
      E_valA = va; E_valB = vb; E_valC = vc; E_dstE = de; E_dstM = dm;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs an already-presented mulq to completion; optionally raises m_stat to SADR after edge sadr_at
   task automatic run_mul(input int sadr_at, output int cycles, output bit bub_ok);
      cycles = 1;
      bub_ok = 1'b1;
      for (int k = 0; k < 200; k++) begin
         step();
         if (!e_busy) break;
         cycles++;
         if (e_icode !== I_NOP || e_stat !== S_AOK || e_dstE !== R_NONE || e_dstM !== R_NONE
             || e_valE !== '0 || e_valA !== '0 || e_Cnd !== 1'b0)
            bub_ok = 1'b0;
         if (k == sadr_at) m_stat = S_ADR;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int  cyc;
      bit  bub;
      bit  no_result;
      logic [W-1:0] MINUS5;
      logic [W-1:0] MINVAL;
      logic [W-1:0] MAXVAL;
      MINUS5 = -64'sd5;
      MINVAL = 64'h8000_0000_0000_0000;
      MAXVAL = 64'h7FFF_FFFF_FFFF_FFFF;

      rst = 1'b1;
      m_stat = S_AOK;
      W_stat = S_AOK;
      drive(S_AOK, I_NOP, 4'd0, '0, '0, '0, R_NONE, R_NONE);
      #12;
      chk("rst_busy",  e_busy,  0);
      chk("rst_stat",  e_stat,  S_AOK);
      chk("rst_icode", e_icode, I_NOP);
      chk("rst_cnd",   e_Cnd,   0);
      chk("rst_valE",  e_valE,  0);
      chk("rst_valA",  e_valA,  0);
      chk("rst_dstE",  e_dstE,  R_NONE);
      chk("rst_dstM",  e_dstM,  R_NONE);
      rst = 1'b0;

      //        stat   icode     ifun va      vb          vc      dE     dM      mst    wst    xstat  xc  cv  xvalE      xdstE
      vt.push_back(mk(S_AOK, I_JXX,    3, 0,      0,          0,      R_NONE, R_NONE, S_AOK, S_AOK, S_AOK, 1, 1, 0,         R_NONE));
      vt.push_back(mk(S_AOK, I_OPQ,    0, 5,      MINUS5,     0,      2,      R_NONE, S_AOK, S_AOK, S_AOK, 0, 1, 0,         2));
      vt.push_back(mk(S_AOK, I_JXX,    4, 0,      0,          0,      R_NONE, R_NONE, S_AOK, S_AOK, S_AOK, 0, 1, 0,         R_NONE));
      vt.push_back(mk(S_AOK, I_OPQ,    1, 1,      MINVAL,     0,      3,      R_NONE, S_AOK, S_AOK, S_AOK, 0, 1, MAXVAL,    3));
      vt.push_back(mk(S_AOK, I_RRMOVQ, 2, 'h55,   0,          0,      5,      R_NONE, S_AOK, S_AOK, S_AOK, 1, 1, 'h55,      5));
      vt.push_back(mk(S_AOK, I_RRMOVQ, 3, 'h66,   0,          0,      6,      R_NONE, S_AOK, S_AOK, S_AOK, 0, 1, 'h66,      R_NONE));
      vt.push_back(mk(S_AOK, I_OPQ,    0, 3,      4,          0,      1,      R_NONE, S_ADR, S_AOK, S_AOK, 0, 1, 7,         1));
      vt.push_back(mk(S_AOK, I_JXX,    3, 0,      0,          0,      R_NONE, R_NONE, S_AOK, S_AOK, S_AOK, 0, 1, 0,         R_NONE));
      vt.push_back(mk(S_AOK, I_JXX,    2, 0,      0,          0,      R_NONE, R_NONE, S_AOK, S_AOK, S_AOK, 1, 1, 0,         R_NONE));
      vt.push_back(mk(S_AOK, I_OPQ,    2, 'hF0,   'h0F,       0,      1,      R_NONE, S_AOK, S_HLT, S_AOK, 0, 1, 0,         1));
      vt.push_back(mk(S_AOK, I_JXX,    4, 0,      0,          0,      R_NONE, R_NONE, S_AOK, S_AOK, S_AOK, 1, 1, 0,         R_NONE));
      vt.push_back(mk(S_AOK, I_OPQ,    3, 'hFF00, 'h0FF0,     0,      8,      R_NONE, S_AOK, S_AOK, S_AOK, 0, 1, 'hF0F0,    8));
      vt.push_back(mk(S_AOK, I_JXX,    6, 0,      0,          0,      R_NONE, R_NONE, S_AOK, S_AOK, S_AOK, 1, 1, 0,         R_NONE));
      vt.push_back(mk(S_AOK, I_OPQ,    9, 1,      2,          0,      7,      R_NONE, S_AOK, S_AOK, S_INS, 0, 0, 0,         R_NONE));
      vt.push_back(mk(S_AOK, I_JXX,    4, 0,      0,          0,      R_NONE, R_NONE, S_AOK, S_AOK, S_AOK, 1, 1, 0,         R_NONE));
      vt.push_back(mk(S_AOK, I_OPQ,    0, MAXVAL, 1,          0,      9,      R_NONE, S_AOK, S_AOK, S_AOK, 0, 1, MINVAL,    9));
      vt.push_back(mk(S_AOK, I_JXX,    2, 0,      0,          0,      R_NONE, R_NONE, S_AOK, S_AOK, S_AOK, 0, 1, 0,         R_NONE));
      vt.push_back(mk(S_AOK, I_JXX,    1, 0,      0,          0,      R_NONE, R_NONE, S_AOK, S_AOK, S_AOK, 0, 1, 0,         R_NONE));
      vt.push_back(mk(S_AOK, I_CALL,   0, 0,      'h100,      0,      R_ESP,  R_NONE, S_AOK, S_AOK, S_AOK, 0, 1, 'hF8,      R_ESP));
      vt.push_back(mk(S_AOK, I_POPQ,   0, 0,      'h100,      0,      R_ESP,  5,      S_AOK, S_AOK, S_AOK, 0, 1, 'h108,     R_ESP));
      vt.push_back(mk(S_AOK, I_PUSHQ,  0, 'h9,    'h40,       0,      R_ESP,  R_NONE, S_AOK, S_AOK, S_AOK, 0, 1, 'h38,      R_ESP));
      vt.push_back(mk(S_AOK, I_RET,    0, 0,      'h50,       0,      R_ESP,  R_NONE, S_AOK, S_AOK, S_AOK, 0, 1, 'h58,      R_ESP));
      vt.push_back(mk(S_AOK, I_IRMOVQ, 0, 0,      0,          'h1234, 3,      R_NONE, S_AOK, S_AOK, S_AOK, 0, 1, 'h1234,    3));
      vt.push_back(mk(S_AOK, I_MRMOVQ, 0, 0,      'h20,       8,      R_NONE, 3,      S_AOK, S_AOK, S_AOK, 0, 1, 'h28,      R_NONE));
      vt.push_back(mk(S_AOK, I_RMMOVQ, 0, 'hAB,   'h30,       'h10,   R_NONE, R_NONE, S_AOK, S_AOK, S_AOK, 0, 1, 'h40,      R_NONE));
      vt.push_back(mk(S_AOK, I_JXX,    7, 0,      0,          0,      R_NONE, R_NONE, S_AOK, S_AOK, S_AOK, 0, 1, 0,         R_NONE));
      vt.push_back(mk(S_HLT, I_HALT,   0, 0,      0,          0,      R_NONE, R_NONE, S_AOK, S_AOK, S_HLT, 0, 1, 0,         R_NONE));
      vt.push_back(mk(S_AOK, I_RRMOVQ, 0, 'h77,   0,          0,      10,     R_NONE, S_AOK, S_AOK, S_AOK, 1, 1, 'h77,      10));

      foreach (vt[i]) begin
         drive(vt[i].stat, vt[i].icode, vt[i].ifun, vt[i].valA, vt[i].valB, vt[i].valC,
               vt[i].dstE, vt[i].dstM);
         m_stat = vt[i].mst;
         W_stat = vt[i].wst;
         step();
         chk($sformatf("v%0d_stat", i),  e_stat,  vt[i].x_stat);
         chk($sformatf("v%0d_icode", i), e_icode, vt[i].icode);
         chk($sformatf("v%0d_cnd", i),   e_Cnd,   vt[i].x_cnd);
         chk($sformatf("v%0d_valA", i),  e_valA,  vt[i].valA);
         chk($sformatf("v%0d_dstE", i),  e_dstE,  vt[i].x_dstE);
         chk($sformatf("v%0d_dstM", i),  e_dstM,  vt[i].dstM);
         if (vt[i].chk_val) chk($sformatf("v%0d_valE", i), e_valE, vt[i].x_valE);
      end
      m_stat = S_AOK;
      W_stat = S_AOK;

      // mulq 7*6: busy rises combinationally, WIDTH busy cycles of bubbles, then result
      drive(S_AOK, I_OPQ, ALU_MUL, 7, 6, 0, 2, R_NONE);
      #1;
      chk("mul_busy_rise", e_busy, 1);
      chk("nomul_busy",    n_busy, 0);
      run_mul(-1, cyc, bub);
      chk("nomul_stat",  n_stat, S_INS);
      chk("nomul_dstE",  n_dstE, R_NONE);
      chk("mul_cycles",  cyc, 64);
      chk("mul_bubbles", bub, 1);
      chk("mul_valE",    e_valE, 42);
      chk("mul_icode",   e_icode, I_OPQ);
      chk("mul_dstE",    e_dstE, 2);
      chk("mul_stat",    e_stat, S_AOK);
      chk("mul_busy_end", e_busy, 0);
      step();
      chk("mul_post_bubble", e_icode, I_NOP);

      // Back-to-back mulq 0*5; M goes SADR just before the completion edge, so CC must hold
      drive(S_AOK, I_OPQ, ALU_MUL, 0, 5, 0, 3, R_NONE);
      #1;
      chk("mul2_busy_rise", e_busy, 1);
      run_mul(62, cyc, bub);
      chk("mul2_cycles", cyc, 64);
      chk("mul2_valE",   e_valE, 0);
      chk("mul2_dstE",   e_dstE, 3);
      m_stat = S_AOK;
      step();
      drive(S_AOK, I_JXX, 3, 0, 0, 0, R_NONE, R_NONE);
      step();
      chk("je_after_mul", e_Cnd, 0);
      drive(S_AOK, I_JXX, 6, 0, 0, 0, R_NONE, R_NONE);
      step();
      chk("jg_after_mul", e_Cnd, 1);

      // Reset in the middle of a multiply
      drive(S_AOK, I_OPQ, ALU_MUL, 3, 5, 0, 4, R_NONE);
      for (int k = 0; k < 10; k++) step();
      rst = 1'b1;
      #1;
      chk("abort_busy",  e_busy,  0);
      chk("abort_icode", e_icode, I_NOP);
      chk("abort_stat",  e_stat,  S_AOK);
      chk("abort_valE",  e_valE,  0);
      chk("abort_dstE",  e_dstE,  R_NONE);
      chk("abort_dstM",  e_dstM,  R_NONE);
      drive(S_AOK, I_NOP, 0, 0, 0, 0, R_NONE, R_NONE);
      #3;
      rst = 1'b0;
      no_result = 1'b1;
      for (int k = 0; k < 70; k++) begin
         step();
         if (e_icode !== I_NOP || e_valE !== '0 || e_busy !== 1'b0) no_result = 1'b0;
      end
      chk("abort_no_result", no_result, 1);
      drive(S_AOK, I_JXX, 3, 0, 0, 0, R_NONE, R_NONE);
      step();
      chk("je_after_reset", e_Cnd, 1);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
